// File: rtl/sysbus_arbiter.sv
// Two-port (ifetch/dmem) round-robin arbiter onto a single Sysbus; one owner per line transfer.
// Request appears the cycle after the pick, held until bus_reqack; read beats forwarded combinationally.
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 4'h5
`endif

module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p0_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] p0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p0_reqtag,
  input  logic [BUS_DATA_WIDTH-1:0] p0_wdata,
  output logic                      p0_gnt,
  output logic                      p0_wbeat,
  output logic                      p0_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] p0_resp,
  input  logic                      p1_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] p1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p1_reqtag,
  input  logic [BUS_DATA_WIDTH-1:0] p1_wdata,
  output logic                      p1_gnt,
  output logic                      p1_wbeat,
  output logic                      p1_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] p1_resp,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      err_stray
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_q, last_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BUS_DATA_WIDTH-1:0] req_q, req_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;

  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_wdata;
  logic                      is_write;
  logic                      unused_resptag;

  assign own_reqcyc     = owner_q ? p1_reqcyc : p0_reqcyc;
  assign own_wdata      = owner_q ? p1_wdata : p0_wdata;
  assign is_write       = (tag_q[11:8] == `SYSBUS_WRITE);
  assign unused_resptag = ^bus_resptag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      req_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    tag_d       = tag_q;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    p0_wbeat    = 1'b0;
    p1_wbeat    = 1'b0;
    p0_respcyc  = 1'b0;
    p1_respcyc  = 1'b0;
    p0_resp     = '0;
    p1_resp     = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    err_stray   = 1'b0;

    // Outputs are forced quiet while reset is held so an abort takes effect at once.
    if (!reset) begin
      err_stray = bus_respcyc && (state_q != RESP);
      case (state_q)
        IDLE: begin
          if (p0_reqcyc || p1_reqcyc) begin
            // last_q names the port granted most recently; the other wins a tie.
            owner_d = (p0_reqcyc && p1_reqcyc) ? ~last_q : p1_reqcyc;
            req_d   = owner_d ? p1_req : p0_req;
            tag_d   = owner_d ? p1_reqtag : p0_reqtag;
            state_d = REQ;
          end
        end
        REQ: begin
          bus_reqcyc = 1'b1;
          bus_req    = req_q;
          bus_reqtag = tag_q;
          if (bus_reqack) begin
            p0_gnt  = !owner_q;
            p1_gnt  = owner_q;
            last_d  = owner_q;
            cnt_d   = '0;
            state_d = is_write ? WDATA : RESP;
          end else if (!own_reqcyc) begin
            state_d = IDLE;
          end
        end
        WDATA: begin
          bus_reqcyc = 1'b1;
          bus_req    = own_wdata;
          bus_reqtag = tag_q;
          p0_wbeat   = !owner_q;
          p1_wbeat   = owner_q;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RESP: begin
          bus_respack = bus_respcyc;
          if (bus_respcyc) begin
            p0_respcyc = !owner_q;
            p1_respcyc = owner_q;
            p0_resp    = owner_q ? '0 : bus_resp;
            p1_resp    = owner_q ? bus_resp : '0;
            if (cnt_q == LAST_BEAT) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
